// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the memory target and the bench bus driver.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // First byte after START: 7-bit address followed by R/W (1 = read).
    function automatic logic [7:0] addr_byte(input logic [6:0] addr7, input logic rw);
        return {addr7, rw};
    endfunction

endpackage

// File: rtl/i2c_mem_target_if.sv
// Bus pins plus host-side write strobe and backdoor read port of the I2C memory target.
interface i2c_mem_target_if #(
    parameter int PTR_W = 4
);
    logic             scl_i;
    logic             sda_i;
    logic             sda_oe;
    logic             busy;
    logic             wr_valid;
    logic [PTR_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic [PTR_W-1:0] host_raddr;
    logic [7:0]       host_rdata;

    modport slave (
        input  scl_i, sda_i, host_raddr,
        output sda_oe, busy, wr_valid, wr_addr, wr_data, host_rdata
    );

    modport master (
        output scl_i, sda_i, host_raddr,
        input  sda_oe, busy, wr_valid, wr_addr, wr_data, host_rdata
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges, START and STOP.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    assign scl_s = scl_sr[SYNC_STAGES-1];
    assign sda_s = sda_sr[SYNC_STAGES-1];

    // Synchroniser chains plus one delayed copy for edge detection; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
        end
    end

    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  sda_d & ~sda_s;
    assign stop_det  =  scl_s & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_mem_target.sv
// I2C target with a byte register file, auto-incrementing pointer and burst read/write.
module i2c_mem_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h55,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    i2c_mem_target_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e       state, state_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic             sda_oe, sda_oe_n;
    logic             busy, busy_n;
    logic             wr_valid, wr_valid_n;
    logic [PTR_W-1:0] wr_addr, wr_addr_n;
    logic [7:0]       wr_data, wr_data_n;
    logic             mem_we;
    logic [7:0]       mem [DEPTH];

    logic [7:0]       byte_in;
    logic [PTR_W-1:0] ptr_inc;
    logic             ptr_ok;

    // The byte completes on the 8th rise, so fold the live SDA sample in.
    assign byte_in = {shreg[6:0], sda_s};
    assign ptr_inc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign ptr_ok  = ({1'b0, byte_in} < 9'(DEPTH));

    // Next-state and datapath decode; START/STOP override any bit event.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        ptr_n      = ptr;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        wr_valid_n = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        mem_we     = 1'b0;

        if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (state)
                                ADDR: begin
                                    if (byte_in[7:1] == TARGET_ADDR) begin
                                        state_n = ADDR_ACK;
                                        busy_n  = 1'b1;
                                    end else begin
                                        state_n = IGNORE;
                                        busy_n  = 1'b0;
                                    end
                                end
                                PTR: begin
                                    if (ptr_ok) begin
                                        ptr_n   = byte_in[PTR_W-1:0];
                                        state_n = PTR_ACK;
                                    end else begin
                                        state_n = IGNORE;
                                    end
                                end
                                default: begin
                                    mem_we     = 1'b1;
                                    wr_valid_n = 1'b1;
                                    wr_addr_n  = ptr;
                                    wr_data_n  = byte_in;
                                    ptr_n      = ptr_inc;
                                    state_n    = WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end

                // First fall after the byte starts the ACK; the second ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            bit_cnt_n = '0;
                            if (state == ADDR_ACK && shreg[0]) begin
                                shreg_n  = mem[ptr];
                                sda_oe_n = ~mem[ptr][7];
                                state_n  = RDATA;
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                end

                // shreg[7] is the bit currently on the wire.
                RDATA: begin
                    if (scl_fall) begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                    end else if (scl_rise) begin
                        if (bit_cnt == 3'd7) begin
                            state_n   = RACK;
                            ptr_n     = ptr_inc;
                            bit_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end

                // bit_cnt[0] marks that the master has ACKed and another byte follows.
                RACK: begin
                    if (scl_fall) begin
                        if (bit_cnt[0]) begin
                            shreg_n   = mem[ptr];
                            sda_oe_n  = ~mem[ptr][7];
                            bit_cnt_n = '0;
                            state_n   = RDATA;
                        end else begin
                            sda_oe_n = 1'b0;
                        end
                    end else if (scl_rise) begin
                        if (sda_s == ACK) begin
                            bit_cnt_n = 3'd1;
                        end else begin
                            state_n  = IGNORE;
                            sda_oe_n = 1'b0;
                        end
                    end
                end

                IDLE, IGNORE: ;

                default: state_n = IDLE;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            ptr      <= ptr_n;
            sda_oe   <= sda_oe_n;
            busy     <= busy_n;
            wr_valid <= wr_valid_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
        end
    end

    // Register file, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[ptr] <= byte_in;
        end
    end

    assign bus.sda_oe     = sda_oe;
    assign bus.busy       = busy;
    assign bus.wr_valid   = wr_valid;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;
    assign bus.host_rdata = mem[bus.host_raddr];

endmodule
